// File: rtl/toast_regfile.sv
// 32x32 register file with write-through bypass and a per-register
// pending-write scoreboard driving the ID stall signal.
module toast_regfile #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_rs1_addr_i,
  input  logic [4:0]  ID_rs2_addr_i,
  output logic [31:0] ID_rs1_data_o,
  output logic [31:0] ID_rs2_data_o,
  input  logic [4:0]  WB_rd_addr_i,
  input  logic [31:0] WB_rd_wr_data_i,
  input  logic        WB_rd_wr_en_i,
  input  logic        ID_issue_i,
  input  logic [4:0]  ID_issue_rd_addr_i,
  input  logic        EX_kill_i,
  input  logic [4:0]  EX_kill_rd_addr_i,
  output logic        ID_hazard_o,
  output logic        sb_overflow_o
);

  localparam int unsigned SUM_W = CNT_W + 2;

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic             ovf_q, ovf_d;

  logic             inc;
  logic [1:0]       dec;
  logic [SUM_W-1:0] sum;
  logic             wbret1, wbret2;
  logic             busy1, busy2;

  always_comb begin
    regs_d = regs_q;
    if (WB_rd_wr_en_i && (WB_rd_addr_i != 5'd0)) begin
      regs_d[WB_rd_addr_i] = WB_rd_wr_data_i;
    end
  end

  // Saturated issue with no retire holds the count and raises the sticky flag;
  // otherwise net the events in a wider sum and clamp at zero.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    inc    = 1'b0;
    dec    = 2'd0;
    sum    = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc = ID_issue_i && (ID_issue_rd_addr_i == r[4:0]);
      dec = 2'(WB_rd_wr_en_i && (WB_rd_addr_i == r[4:0]))
          + 2'(EX_kill_i && (EX_kill_rd_addr_i == r[4:0]));
      if (inc && (pend_q[r[4:0]] == '1) && (dec == 2'd0)) begin
        ovf_d = 1'b1;
      end else begin
        sum = SUM_W'(pend_q[r[4:0]]) + SUM_W'(inc);
        pend_d[r[4:0]] = (sum < SUM_W'(dec)) ? '0 : CNT_W'(sum - SUM_W'(dec));
      end
    end
  end

  always_comb begin
    wbret1 = WB_rd_wr_en_i && (WB_rd_addr_i == ID_rs1_addr_i);
    wbret2 = WB_rd_wr_en_i && (WB_rd_addr_i == ID_rs2_addr_i);

    if (ID_rs1_addr_i == 5'd0)  ID_rs1_data_o = '0;
    else if (wbret1)            ID_rs1_data_o = WB_rd_wr_data_i;
    else                        ID_rs1_data_o = regs_q[ID_rs1_addr_i];

    if (ID_rs2_addr_i == 5'd0)  ID_rs2_data_o = '0;
    else if (wbret2)            ID_rs2_data_o = WB_rd_wr_data_i;
    else                        ID_rs2_data_o = regs_q[ID_rs2_addr_i];

    busy1 = (ID_rs1_addr_i != 5'd0) && (pend_q[ID_rs1_addr_i] > CNT_W'(wbret1));
    busy2 = (ID_rs2_addr_i != 5'd0) && (pend_q[ID_rs2_addr_i] > CNT_W'(wbret2));
    ID_hazard_o = busy1 || busy2;
  end

  assign sb_overflow_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
      pend_q <= '{default: '0};
      ovf_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_toast_regfile.sv
// Scoreboarded bench for toast_regfile: a behavioural model queues expected
// outputs each cycle, and they are popped and compared mid-cycle.
module tb_toast_regfile;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, wb_addr, iss_addr, kill_addr;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_en, iss, kill, hazard, ovf;

  always #5 clk = ~clk;

  toast_regfile #(.CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ID_rs1_addr_i     (rs1),
    .ID_rs2_addr_i     (rs2),
    .ID_rs1_data_o     (rd1),
    .ID_rs2_data_o     (rd2),
    .WB_rd_addr_i      (wb_addr),
    .WB_rd_wr_data_i   (wb_data),
    .WB_rd_wr_en_i     (wb_en),
    .ID_issue_i        (iss),
    .ID_issue_rd_addr_i(iss_addr),
    .EX_kill_i         (kill),
    .EX_kill_rd_addr_i (kill_addr),
    .ID_hazard_o       (hazard),
    .sb_overflow_o     (ovf)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_reg [32];
  int          m_pend[32];
  bit          m_ovf;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    int wr;
    if (a == 0) return 1'b0;
    wr = (wb_en && wb_addr == a) ? 1 : 0;
    return (m_pend[a] - wr) > 0;
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic eval();
    exp_t        e;
    logic [31:0] got;
    #4;
    push("rd1", 0, m_read(rs1));
    push("rd2", 1, m_read(rs2));
    push("hazard", 2, {31'h0, m_busy(rs1) | m_busy(rs2)});
    push("ovf", 3, {31'h0, m_ovf});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       got = rd1;
        1:       got = rd2;
        2:       got = {31'h0, hazard};
        default: got = {31'h0, ovf};
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 0;
    end
    m_ovf = 1'b0;
  endtask

  task automatic adv();
    int ic, dc, n;
    if (rst) model_reset();
    else begin
      for (int r = 1; r < 32; r++) begin
        ic = (iss && iss_addr == r) ? 1 : 0;
        dc = ((wb_en && wb_addr == r) ? 1 : 0) + ((kill && kill_addr == r) ? 1 : 0);
        if (ic == 1 && m_pend[r] == MAXC && dc == 0) m_ovf = 1'b1;
        else begin
          n = m_pend[r] + ic - dc;
          m_pend[r] = (n < 0) ? 0 : n;
        end
      end
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    iss = 1'b0; iss_addr = 5'd0; kill = 1'b0; kill_addr = 5'd0;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    rs1 = 5'd5; rs2 = 5'd31; eval();
    check("rst_rd1", rd1, 32'h0);
    check("rst_hazard", {31'h0, hazard}, 32'h0);
    adv();

    // write/read, x0 discard
    idle(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; step();
    idle(); rs1 = 5'd5; eval(); check("x5_read", rd1, 32'hDEADBEEF); adv();
    idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs2 = 5'd0; step();
    idle(); rs2 = 5'd0; eval(); check("x0_read", rd2, 32'h0); adv();

    // bypass
    idle(); wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5; rs1 = 5'd7; rs2 = 5'd7;
    eval(); check("byp_rd1", rd1, 32'hA5A5A5A5); check("byp_rd2", rd2, 32'hA5A5A5A5); adv();

    // hazard on x3, cleared by its writeback in the strobe cycle
    idle(); iss = 1'b1; iss_addr = 5'd3; rs1 = 5'd3;
    eval(); check("iss_same_cycle", {31'h0, hazard}, 32'h0); adv();
    idle(); rs1 = 5'd3; eval(); check("haz_x3", {31'h0, hazard}, 32'h1); adv();
    idle(); rs1 = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    eval(); check("haz_x3_wb", {31'h0, hazard}, 32'h0); check("byp_x3", rd1, 32'h33); adv();
    idle(); rs1 = 5'd3; step();

    // simultaneous events on x4, kill on idle x6
    idle(); iss = 1'b1; iss_addr = 5'd4; step(); step();
    idle(); iss = 1'b1; iss_addr = 5'd4; kill = 1'b1; kill_addr = 5'd4;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44; rs1 = 5'd4; step();
    idle(); rs1 = 5'd4; eval(); check("pend4_one", {31'h0, hazard}, 32'h1); adv();
    idle(); rs1 = 5'd4; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h45;
    eval(); check("pend4_last", {31'h0, hazard}, 32'h0); adv();
    idle(); kill = 1'b1; kill_addr = 5'd6; step();
    idle(); rs2 = 5'd6; eval();
    check("kill6_hazard", {31'h0, hazard}, 32'h0); check("kill6_noflag", {31'h0, ovf}, 32'h0); adv();

    // saturation on x9 then three retires
    idle(); iss = 1'b1; iss_addr = 5'd9; step(); step(); step();
    eval(); check("ovf_not_yet", {31'h0, ovf}, 32'h0); adv();
    idle(); rs1 = 5'd9; eval(); check("ovf_set", {31'h0, ovf}, 32'h1); adv();
    for (int k = 0; k < 3; k++) begin
      idle(); rs1 = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h900 + k;
      eval(); check("x9_retire", {31'h0, hazard}, (k == 2) ? 32'h0 : 32'h1); adv();
    end

    // reset mid-operation with inputs that must be ignored
    idle(); iss = 1'b1; iss_addr = 5'd12; step(); step();
    idle(); wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hFF; iss = 1'b1; iss_addr = 5'd12; step();
    idle(); rst = 1'b1; iss = 1'b1; iss_addr = 5'd12; wb_en = 1'b1; wb_addr = 5'd12;
    wb_data = 32'h77; kill = 1'b1; kill_addr = 5'd12; adv();
    idle(); rs1 = 5'd12; eval();
    check("rst_x12", rd1, 32'h0); check("rst_haz12", {31'h0, hazard}, 32'h0);
    check("rst_ovf", {31'h0, ovf}, 32'h0); adv();

    // random traffic over a small register window
    for (int c = 0; c < 400; c++) begin
      idle();
      rst       = ($urandom_range(0, 63) == 0);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      iss       = $urandom_range(0, 2) != 0;
      iss_addr  = 5'($urandom_range(0, 7));
      kill      = $urandom_range(0, 3) == 0;
      kill_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
